// File: rtl/stump_mem_responder.sv
// stump_mem_responder: bridges Stump core mem_ren/mem_wen accesses onto a req/ack external memory port (optional timeout: STUMP_MEM_TIMEOUT_EN)
module stump_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  output logic              mem_stall,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack,
  output logic              bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t r_state;
  logic r_req, r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_data_in;
  logic w_req;
  assign w_req = mem_ren | mem_wen;
  // stall the core from the request cycle until the single RESP cycle
  assign mem_stall = (r_state == IDLE) ? w_req : (r_state == REQ);
  assign ext_req = r_req;
  assign ext_we = r_we;
  assign ext_addr = r_addr;
  assign ext_wdata = r_wdata;
  assign data_in = r_data_in;
`ifdef STUMP_MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] r_cnt;
  logic r_bus_err;
  assign bus_err = r_bus_err;
`else
  assign bus_err = 1'b0;
`endif
  // access FSM: latch core request in IDLE, hold it on the bus until ack (or timeout), release core in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_data_in <= '0;
`ifdef STUMP_MEM_TIMEOUT_EN
      r_cnt <= '0;
      r_bus_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_addr <= address;
          r_wdata <= data_out;
          r_we <= mem_wen;
          r_req <= 1'b1;
          r_state <= REQ;
`ifdef STUMP_MEM_TIMEOUT_EN
          r_cnt <= '0;
`endif
        end
        REQ: if (ext_ack) begin
          r_req <= 1'b0;
          if (!r_we) r_data_in <= ext_rdata;
          r_state <= RESP;
        end
`ifdef STUMP_MEM_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          r_req <= 1'b0;
          if (!r_we) r_data_in <= ERR_DATA;
          r_bus_err <= 1'b1;
          r_state <= RESP;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/stump_mem_responder.md
Name: stump_mem_responder

Overview:
- Memory-side responder for the Stump datapath. It answers the processor's mem_ren/mem_wen accesses (fetch, load and store) and bridges them onto a slow external memory port that uses a req/ack handshake.
- While an access is outstanding it asserts mem_stall, and the processor freezes its state.
- It sits between the Stump core and the memory/peripheral bus, at the opposite end of the control decoder's memory-enable outputs.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT, 255, maximum REQ cycles before an abort. Used only with the optional feature.
- ERR_DATA, 16'hDEAD, read data returned on a timeout abort.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_ren  input  1  read request from the core (fetch or load).
- mem_wen  input  1  write request from the core (store).
- address  input  ADDR_W  access address from the core.
- data_out  input  DATA_W  store data from the core.
- data_in  output  DATA_W  read data to the core (registered).
- mem_stall  output  1  hold the core; access not yet complete.
- ext_req  output  1  external request (registered).
- ext_we  output  1  external write strobe, valid with ext_req.
- ext_addr  output  ADDR_W  external address, valid with ext_req.
- ext_wdata  output  DATA_W  external write data, valid with ext_req.
- ext_rdata  input  DATA_W  external read data, valid in the ext_ack cycle.
- ext_ack  input  1  external completion; one-cycle pulse.
- bus_err  output  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, data_in=0, bus_err=0, timeout counter=0.
- States:
  - IDLE: no access outstanding.
  - REQ: external access in flight.
  - RESP: access done; release the core.
- IDLE:
  - mem_stall = mem_ren | mem_wen (combinational), so the core stalls in the same cycle it requests.
  - On a request: latch address and data_out into ext_addr and ext_wdata; ext_we=mem_wen; ext_req<=1; go to REQ.
  - If mem_ren and mem_wen are both high, the write wins (ext_we=1).
- REQ:
  - mem_stall=1.
  - ext_req and its address/data fields are held stable until ext_ack is sampled high.
  - On ext_ack: ext_req<=0; for a read, data_in<=ext_rdata; for a write, data_in is unchanged; go to RESP.
  - ext_ack seen in IDLE or RESP is ignored.
- RESP:
  - mem_stall=0 for exactly one cycle; the core advances on this edge.
  - Next state is IDLE unconditionally. The request still visible in the RESP cycle is the completed one and is never re-issued.
  - A new request is first recognised in the following IDLE cycle.
- Latency:
  - Request in cycle 0, ext_req high in cycle 1. The earliest ack is cycle 1, giving RESP in cycle 2.
  - Minimum 3 cycles per access; each extra cycle before ext_ack adds one cycle.
- Core inputs (address, data_out, enables) are sampled only in IDLE; later changes have no effect on the access in flight.
- Reset mid-access: ext_req drops asynchronously and the in-flight access is abandoned. Any later ext_ack is ignored because the block is back in IDLE.
- No back-to-back pipelining: at most one outstanding external access.

Optional Feature:
- Macro: STUMP_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ext_ack.
  - When it reaches TIMEOUT: ext_req<=0; for a read, data_in<=ERR_DATA; bus_err<=1 (sticky until rst_n); go to RESP.
  - ext_ack arriving in the same cycle as the timeout has priority, and the access completes normally.
- Undefined: no counter; REQ waits for ext_ack indefinitely; bus_err is tied to 0.

Test Plan:
- Read, zero wait: mem_ren=1, address=16'h0040; ext_ack in the first REQ cycle with ext_rdata=16'h1234. Required: mem_stall=1,1,0 over cycles 0–2; data_in=16'h1234 in cycle 2; ext_addr=16'h0040.
- Write, 4 wait cycles: mem_wen=1, address=16'h0100, data_out=16'hBEEF. Required: ext_we=1 and ext_wdata=16'hBEEF held for 5 cycles; mem_stall low only in the RESP cycle; data_in unchanged.
- Simultaneous ren and wen: both high at address 16'h0002. Required: ext_we=1, a single access, no read update of data_in.
- Back-to-back: two reads, 16'h0000 then 16'h0001, with ack=1 immediately. Required: exactly two ext_req assertions separated by one idle cycle; no duplicate issue from the RESP cycle.
- Reset mid-access: drop rst_n in REQ, then pulse ext_ack after release. Required: ext_req falls without waiting for a clock edge; the state stays IDLE; data_in=0.
- With STUMP_MEM_TIMEOUT_EN and TIMEOUT=8: read with ext_ack never asserted. Required: RESP after 8 REQ cycles, data_in=16'hDEAD, bus_err=1 and remaining set through subsequent accesses.
